// File: rtl/mips_run_controller_if.sv
// Dump stream between the run controller and a downstream checker.
// Valid/ready handshake: a beat transfers when both are high on a rising edge.
interface mips_run_controller_if;
  logic        valid;
  logic        ready;
  logic [7:0]  index;
  logic [31:0] data;

  modport master (output valid, output index, output data, input ready);
  modport slave  (input valid, input index, input data, output ready);
endinterface

// File: rtl/mips_run_controller.sv
// Run sequencer for the single-cycle MIPS core: releases the core on start,
// ends the run on a NOP streak or watchdog, then dumps a data-memory window.
module mips_run_controller #(
  parameter int unsigned NOP_LIMIT  = 9,
  parameter int unsigned WATCHDOG   = 500,
  parameter int unsigned DUMP_WORDS = 22,
  parameter int unsigned DUMP_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            inst,
  output logic                   cpu_rst_n,
  input  logic [31:0]            cpu_data_addr,
  input  logic [31:0]            cpu_data_in,
  input  logic                   cpu_data_wr,
  output logic [31:0]            cpu_data_out,
  output logic [31:0]            mem_data_addr,
  output logic [31:0]            mem_data_in,
  output logic                   mem_data_wr,
  input  logic [31:0]            mem_data_out,
  mips_run_controller_if.master  dump,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout
);

  localparam int unsigned NopW = $clog2(NOP_LIMIT + 1);
  localparam int unsigned CycW = $clog2(WATCHDOG + 1);

  typedef enum logic [2:0] {StIdle, StRun, StDumpRd, StDumpOut, StDone} state_e;

  state_e            state_q, state_d;
  logic [NopW-1:0]   nop_cnt_q, nop_cnt_d;
  logic [CycW-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [7:0]        idx_q, idx_d;
  logic              timeout_q, timeout_d;
  logic              cpu_rst_n_q;
  logic [31:0]       dump_data_q, dump_data_d;
  logic [7:0]        dump_index_q, dump_index_d;
  logic              halt, wd_expire;

  // State and datapath registers; core reset follows the next state so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      nop_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      idx_q        <= '0;
      timeout_q    <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      dump_data_q  <= '0;
      dump_index_q <= '0;
    end else begin
      state_q      <= state_d;
      nop_cnt_q    <= nop_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      idx_q        <= idx_d;
      timeout_q    <= timeout_d;
      cpu_rst_n_q  <= (state_d == StRun);
      dump_data_q  <= dump_data_d;
      dump_index_q <= dump_index_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d      = state_q;
    nop_cnt_d    = nop_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    idx_d        = idx_q;
    timeout_d    = timeout_q;
    dump_data_d  = dump_data_q;
    dump_index_d = dump_index_q;
    halt         = (inst == 32'd0) && (nop_cnt_q == NopW'(NOP_LIMIT - 1));
    wd_expire    = (cyc_cnt_q == CycW'(WATCHDOG - 1));
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          nop_cnt_d = '0;
          cyc_cnt_d = '0;
          timeout_d = 1'b0;
        end
      end
      StRun: begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
        nop_cnt_d = (inst == 32'd0) ? nop_cnt_q + 1'b1 : '0;
        if (halt || wd_expire) begin
          state_d   = StDumpRd;
          idx_d     = '0;
          // A halt on the watchdog's last cycle still counts as a clean halt.
          timeout_d = wd_expire && !halt;
        end
      end
      StDumpRd: begin
        dump_data_d  = mem_data_out;
        dump_index_d = idx_q;
        state_d      = StDumpOut;
      end
      StDumpOut: begin
        if (dump.ready) begin
          if (idx_q == 8'(DUMP_WORDS - 1)) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StDumpRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and memory-port ownership, decoded from the registered state.
  always_comb begin
    busy          = (state_q == StRun) || (state_q == StDumpRd) || (state_q == StDumpOut);
    done          = (state_q == StDone);
    dump.valid    = (state_q == StDumpOut);
    if (state_q == StRun) begin
      mem_data_addr = cpu_data_addr;
      mem_data_in   = cpu_data_in;
      mem_data_wr   = cpu_data_wr;
      cpu_data_out  = mem_data_out;
    end else begin
      mem_data_addr = 32'(DUMP_BASE) + {22'd0, idx_q, 2'b00};
      mem_data_in   = 32'd0;
      mem_data_wr   = 1'b0;
      cpu_data_out  = 32'd0;
    end
  end

  assign cpu_rst_n  = cpu_rst_n_q;
  assign timeout    = timeout_q;
  assign dump.data  = dump_data_q;
  assign dump.index = dump_index_q;

endmodule
